multi_tap_echo: RTL and testbench
=================================

MULTI_TAP_ECHO -- requirements
Module: multi_tap_echo

Interface
REQ-001 Parameter DW, default 16: signed sample width.
REQ-002 Parameter DEPTH, default 24000: delay-line length in samples; 500 ms at 48 kHz.
REQ-003 Parameter AW, default 15: address and delay width; must satisfy 2^AW >= DEPTH.
REQ-004 Parameter TAPS, default 2 (range 1..8): number of independent echo taps.
REQ-005 clk  in  1  system clock; all logic is on the rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 din  in  DW  signed input sample.
REQ-008 din_valid  in  1  single-cycle sample strobe.
REQ-009 in_ready  out  1  high when a sample can be accepted.
REQ-010 tap_delay  in  TAPS*AW  packed per-tap delay in samples; tap i occupies bits [i*AW +: AW].
REQ-011 tap_gain  in  TAPS*2  packed per-tap gain code; tap i occupies bits [i*2 +: 2].
REQ-012 echo_en  in  1  1 = echo path active; 0 = bypass.
REQ-013 dout  out  DW  signed output sample.
REQ-014 dout_valid  out  1  single-cycle output strobe.
REQ-015 overrun  out  1  sticky flag set when an input sample is dropped.

Function
REQ-016 Storage SHALL be an internal DEPTH x DW RAM with one write port and one read port, and a 1-cycle synchronous read.
REQ-017 wr_ptr SHALL advance by 1 per accepted sample and wrap from DEPTH-1 to 0.
REQ-018 Delay handling per tap:
- Tap i read address SHALL be (wr_ptr - d_i) mod DEPTH.
- A delay d_i > DEPTH-1 SHALL be clamped to DEPTH-1.
- A delay d_i = 0 SHALL make the tap contribute 0.
REQ-019 Gain codes SHALL map as follows:
- 00 = 0
- 01 = x>>>2
- 10 = x>>>1
- 11 = (x>>>1)+(x>>>2)
- All shifts are arithmetic.
REQ-020 FSM states: IDLE, READ, DRAIN, OUT, with in_ready = (state==IDLE).
REQ-021 Accept at cycle T (IDLE with din_valid): latch din, echo_en, tap_delay and tap_gain; go to READ.
REQ-022 READ SHALL issue tap i address at cycle T+1+i for i = 0..TAPS-1, then go to DRAIN.
REQ-023 Tap data SHALL be scaled and summed into an accumulator of width DW+4 during cycles T+2..T+TAPS+1; DRAIN SHALL complete the final accumulate.
REQ-024 OUT, at cycle T+TAPS+2, SHALL do all of the following:
- register dout = sat(din + sum);
- pulse dout_valid;
- write the delay-line word at wr_ptr;
- advance wr_ptr;
- return to IDLE.
REQ-025 Saturation SHALL clamp the sum to [-2^(DW-1), 2^(DW-1)-1].
REQ-026 Latency SHALL be TAPS+2 cycles, and the minimum accepted sample spacing SHALL be TAPS+3 cycles.
REQ-027 din_valid while in_ready=0 SHALL drop the sample, set overrun, and leave the FSM undisturbed.
REQ-028 The delay-line write occurs only in OUT, so a tap with an effective delay of DEPTH-1 reads the oldest stored sample and never the current one.
REQ-029 With echo_en=0 the block SHALL operate in bypass:
- dout=din and dout_valid=din_valid combinationally;
- accepted samples are still written to the delay line (history is preserved);
- dout and dout_valid are never driven from the OUT register.
REQ-030 Tap parameters change only at accept; a mid-sample change SHALL have no effect until the next sample.

Reset
REQ-031 On rst low the block SHALL reset as follows:
- state = IDLE;
- wr_ptr = 0;
- accumulator = 0;
- dout = 0, dout_valid = 0, overrun = 0;
- in_ready = 1 once rst is released.
REQ-032 RAM contents SHALL NOT be cleared by reset.
REQ-033 Reset during READ, DRAIN or OUT SHALL abort the sample: no dout_valid pulse, and no write unless OUT has already been clocked.

Configuration
REQ-034 Macro ECHO_FEEDBACK_EN SHALL select what is written to the delay line:
- Defined: the saturated output sat(din+sum) is written, giving recirculating decaying echoes.
- Undefined: din is written, giving a pure feed-forward multi-tap echo.
- In bypass the value written SHALL be din in both builds.

Verification
REQ-035 Impulse: TAPS=2, d0=100 g0=10, d1=0; din=0x4000 once, then zeros -> dout=0x4000, then 0x2000 exactly 100 samples later, all other outputs 0.
REQ-036 Saturation: din=0x7000, stored tap value 0x7000, gain 11 -> dout=0x7FFF; the negative mirror case -> 0x8000.
REQ-037 Wrap and clamp: d0=30000, more than 24000 samples streamed -> the tap behaves as delay 23999 and the echo is aligned across the wr_ptr wrap.
REQ-038 Overrun: second din_valid 2 cycles after an accept (TAPS=2) -> that sample is dropped, overrun=1, first sample's dout_valid at T+4 unaffected.
REQ-039 Feedback: ECHO_FEEDBACK_EN defined, d0=10 g0=10, impulse 0x4000 -> outputs 0x2000 at sample 10, 0x1000 at 20, 0x0800 at 30; undefined -> only 0x2000 at 10.
REQ-040 Bypass and reset: echo_en=0 -> dout==din in the same cycle; rst asserted during READ -> no dout_valid pulse and in_ready=1 after release.

Source files
------------

// File: rtl/multi_tap_echo.sv
// Multi-tap echo: one delay-line RAM with up to 8 scaled taps summed onto the input sample.
// Define ECHO_FEEDBACK_EN to write the saturated output back into the delay line.
module multi_tap_echo #(
    parameter int unsigned DW    = 16,
    parameter int unsigned DEPTH = 24000,
    parameter int unsigned AW    = 15,
    parameter int unsigned TAPS  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic signed [DW-1:0]   din,
    input  logic                   din_valid,
    output logic                   in_ready,
    input  logic [TAPS*AW-1:0]     tap_delay,
    input  logic [TAPS*2-1:0]      tap_gain,
    input  logic                   echo_en,
    output logic signed [DW-1:0]   dout,
    output logic                   dout_valid,
    output logic                   overrun
);

    localparam int unsigned AccW = DW + 4;
    localparam int unsigned TIW  = (TAPS > 1) ? $clog2(TAPS) : 1;

    localparam logic [AW-1:0]          DMax    = AW'(DEPTH - 1);
    localparam logic [AW-1:0]          DepthA  = AW'(DEPTH);
    localparam logic [TIW-1:0]         LastTap = TIW'(TAPS - 1);
    localparam logic signed [AccW-1:0] SatMax  = AccW'((2 ** (DW - 1)) - 1);
    localparam logic signed [AccW-1:0] SatMin  = ~SatMax;

    typedef enum logic [1:0] {StIdle, StRead, StDrain, StOut} state_e;

    state_e state_q, state_d;

    logic [AW-1:0]          wr_ptr_q;
    logic [DW-1:0]          din_q;
    logic                   en_q;
    logic [TAPS*AW-1:0]     delay_q;
    logic [TAPS*2-1:0]      gain_q;
    logic [TIW-1:0]         tap_idx_q;
    logic [1:0]             rd_gain_q;
    logic                   rd_valid_q;
    logic signed [AccW-1:0] acc_q;
    logic [DW-1:0]          dout_q;
    logic                   dout_valid_q;
    logic                   overrun_q;

    logic [DW-1:0]          mem [DEPTH];
    logic [DW-1:0]          rdata;

    logic [AW-1:0]          cur_d;
    logic [AW-1:0]          eff_d;
    logic [1:0]             cur_g;
    logic [AW-1:0]          raddr;
    logic signed [AccW-1:0] acc_sum;
    logic signed [AccW-1:0] out_sum;
    logic [DW-1:0]          sat_out;
    logic                   ram_we;
    logic [DW-1:0]          wdata;

    function automatic logic signed [AccW-1:0] scale(input logic [DW-1:0] x,
                                                     input logic [1:0]    g);
        logic signed [AccW-1:0] xe;
        xe = {{4{x[DW-1]}}, x};
        case (g)
            2'b01:   scale = xe >>> 2;
            2'b10:   scale = xe >>> 1;
            2'b11:   scale = (xe >>> 1) + (xe >>> 2);
            default: scale = '0;
        endcase
    endfunction

    function automatic logic [DW-1:0] sat(input logic signed [AccW-1:0] s);
        logic signed [AccW-1:0] c;
        if (s > SatMax)      c = SatMax;
        else if (s < SatMin) c = SatMin;
        else                 c = s;
        sat = c[DW-1:0];
    endfunction

    // Tap address generation for the tap currently being issued
    always_comb begin
        cur_d = '0;
        cur_g = '0;
        for (int i = 0; i < TAPS; i++) begin
            if (tap_idx_q == TIW'(i)) begin
                cur_d = delay_q[i*AW +: AW];
                cur_g = gain_q[i*2 +: 2];
            end
        end
        eff_d = (cur_d > DMax) ? DMax : cur_d;
        raddr = (wr_ptr_q >= eff_d) ? (wr_ptr_q - eff_d) : (wr_ptr_q + DepthA - eff_d);
    end

    always_comb begin
        acc_sum = acc_q + (rd_valid_q ? scale(rdata, rd_gain_q) : '0);
        out_sum = {{4{din_q[DW-1]}}, din_q} + acc_sum;
        sat_out = sat(out_sum);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= StIdle;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (din_valid) state_d = StRead;
            StRead:  if (tap_idx_q == LastTap) state_d = StDrain;
            StDrain: state_d = StOut;
            StOut:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready = (state_q == StIdle);
        ram_we   = (state_q == StOut);
`ifdef ECHO_FEEDBACK_EN
        wdata    = en_q ? dout_q : din_q;
`else
        wdata    = din_q;
`endif
        // Bypass is purely combinational and ignores the output register
        dout       = echo_en ? dout_q : din;
        dout_valid = echo_en ? dout_valid_q : din_valid;
        overrun    = overrun_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q     <= '0;
            din_q        <= '0;
            en_q         <= 1'b0;
            delay_q      <= '0;
            gain_q       <= '0;
            tap_idx_q    <= '0;
            rd_gain_q    <= '0;
            rd_valid_q   <= 1'b0;
            acc_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            dout_valid_q <= 1'b0;
            rd_valid_q   <= 1'b0;
            if (din_valid && !in_ready) overrun_q <= 1'b1;
            case (state_q)
                StIdle: begin
                    if (din_valid) begin
                        din_q     <= din;
                        en_q      <= echo_en;
                        delay_q   <= tap_delay;
                        gain_q    <= tap_gain;
                        acc_q     <= '0;
                        tap_idx_q <= '0;
                    end
                end
                StRead: begin
                    rd_valid_q <= 1'b1;
                    // A zero delay is forced to zero gain so the tap adds nothing
                    rd_gain_q  <= (cur_d == '0) ? 2'b00 : cur_g;
                    tap_idx_q  <= tap_idx_q + TIW'(1);
                    acc_q      <= acc_sum;
                end
                StDrain: begin
                    acc_q        <= acc_sum;
                    dout_q       <= sat_out;
                    dout_valid_q <= en_q;
                end
                StOut: begin
                    wr_ptr_q <= (wr_ptr_q == DMax) ? '0 : (wr_ptr_q + AW'(1));
                end
                default: ;
            endcase
        end
    end

    // Delay-line RAM, deliberately not reset
    always_ff @(posedge clk) begin
        if (ram_we) mem[wr_ptr_q] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: tb/tb_multi_tap_echo.sv
// Randomized self-checking bench for multi_tap_echo against an array-based echo model.
module tb_multi_tap_echo;

    localparam int DW    = 16;
    localparam int DEPTH = 300;
    localparam int AW    = 9;
    localparam int TAPS  = 2;
    localparam int DLW   = TAPS * AW;
    localparam int GW    = TAPS * 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [DW-1:0]  din;
    logic           din_valid;
    logic           in_ready;
    logic [DLW-1:0] tap_delay;
    logic [GW-1:0]  tap_gain;
    logic           echo_en;
    logic [DW-1:0]  dout;
    logic           dout_valid;
    logic           overrun;

    int tests = 0;
    int fails = 0;

    int mdl_mem[DEPTH];
    int mdl_wp = 0;

    multi_tap_echo #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .TAPS(TAPS)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .in_ready   (in_ready),
        .tap_delay  (tap_delay),
        .tap_gain   (tap_gain),
        .echo_en    (echo_en),
        .dout       (dout),
        .dout_valid (dout_valid),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [DLW-1:0] mk_dl(input int d0, input int d1);
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        a = AW'(d0);
        b = AW'(d1);
        return {b, a};
    endfunction

    function automatic logic [GW-1:0] mk_gn(input int g0, input int g1);
        logic [1:0] a;
        logic [1:0] b;
        a = 2'(g0);
        b = 2'(g1);
        return {b, a};
    endfunction

    function automatic int gain_of(input int x, input int code);
        case (code)
            1:       return x >>> 2;
            2:       return x >>> 1;
            3:       return (x >>> 1) + (x >>> 2);
            default: return 0;
        endcase
    endfunction

    function automatic int sat16(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Echo model: output = sat(x + sum of gained history samples); history is a circular array
    task automatic model_step(input logic [DW-1:0] xv, input bit en, input logic [DLW-1:0] dl,
                              input logic [GW-1:0] gn, output int y);
        int sum;
        int x;
        int d;
        x = int'($signed(xv));
        sum = 0;
        for (int t = 0; t < TAPS; t++) begin
            d = int'(dl[t*AW +: AW]);
            if (d > DEPTH - 1) d = DEPTH - 1;
            if (d != 0) sum += gain_of(mdl_mem[(mdl_wp - d + DEPTH) % DEPTH], int'(gn[t*2 +: 2]));
        end
        y = en ? sat16(x + sum) : x;
`ifdef ECHO_FEEDBACK_EN
        mdl_mem[mdl_wp] = en ? y : x;
`else
        mdl_mem[mdl_wp] = x;
`endif
        mdl_wp = (mdl_wp + 1) % DEPTH;
    endtask

    task automatic wait_ready(input string name);
        int k;
        k = 0;
        while (in_ready !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (in_ready !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL %s: in_ready=%b after %0d cycles, want 1", name, in_ready, k);
        end
    endtask

    task automatic send(input logic [DW-1:0] x, input bit en, input logic [DLW-1:0] dl,
                        input logic [GW-1:0] gn, input string name, output logic [DW-1:0] got);
        int y;
        int k;
        int lat;
        bit seen;
        logic [DW-1:0] expv;
        wait_ready(name);
        din       = x;
        din_valid = 1'b1;
        echo_en   = en;
        tap_delay = dl;
        tap_gain  = gn;
        model_step(x, en, dl, gn, y);
        expv = DW'(y);
        got  = 'x;
        #1;
        if (!en) begin
            got = dout;
            tests++;
            if (dout !== x || dout_valid !== 1'b1) begin
                fails++;
                $display("FAIL %s bypass: dout=%h valid=%b, want dout=%h valid=1",
                         name, dout, dout_valid, x);
            end
        end
        @(negedge clk);
        din_valid = 1'b0;
        // Scramble inputs mid-sample; latched copies must be used
        din       = DW'($urandom);
        tap_delay = DLW'($urandom);
        tap_gain  = GW'($urandom);
        if (en) begin
            k    = 1;
            lat  = 0;
            seen = 1'b0;
            while (!seen && k <= TAPS + 5) begin
                if (dout_valid === 1'b1) begin
                    seen = 1'b1;
                    lat  = k;
                    got  = dout;
                end else begin
                    @(negedge clk);
                    k++;
                end
            end
            tests++;
            if (!seen || lat != TAPS + 2 || got !== expv) begin
                fails++;
                $display("FAIL %s: seen=%b latency=%0d dout=%h, want latency %0d dout=%h",
                         name, seen, lat, got, TAPS + 2, expv);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        din = '0;
        din_valid = 1'b0;
        echo_en = 1'b1;
        tap_delay = '0;
        tap_gain = '0;
        repeat (3) @(negedge clk);
        tests++;
        if (dout_valid !== 1'b0 || dout !== '0 || overrun !== 1'b0) begin
            fails++;
            $display("FAIL reset outputs: valid=%b dout=%h overrun=%b, want 0 0000 0",
                     dout_valid, dout, overrun);
        end
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_bypass_prefill;
        logic [DW-1:0] got;
        for (int i = 0; i < 6; i++)
            send(DW'($urandom), 1'b0, DLW'($urandom), GW'($urandom), "bypass_rand", got);
        for (int i = 0; i < DEPTH; i++)
            send('0, 1'b0, '0, '0, "bypass_zero", got);
    endtask

    task automatic test_impulse;
        logic [DW-1:0] got;
        logic [DW-1:0] want;
        for (int i = 0; i < 120; i++) begin
            send((i == 0) ? 16'h4000 : 16'h0000, 1'b1, mk_dl(100, 0), mk_gn(2, 3),
                 "impulse", got);
            want = (i == 0) ? 16'h4000 : ((i == 100) ? 16'h2000 : 16'h0000);
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL impulse[%0d]: got %h want %h", i, got, want);
            end
        end
    endtask

    task automatic test_saturation;
        logic [DW-1:0] got;
        send(16'h7000, 1'b1, mk_dl(1, 0), mk_gn(0, 0), "sat_pos_seed", got);
        send(16'h7000, 1'b1, mk_dl(1, 0), mk_gn(3, 0), "sat_pos", got);
        tests++;
        if (got !== 16'h7FFF) begin
            fails++;
            $display("FAIL sat_pos: got %h want 7fff", got);
        end
        send(16'h9000, 1'b1, mk_dl(1, 0), mk_gn(0, 0), "sat_neg_seed", got);
        send(16'h9000, 1'b1, mk_dl(1, 0), mk_gn(3, 0), "sat_neg", got);
        tests++;
        if (got !== 16'h8000) begin
            fails++;
            $display("FAIL sat_neg: got %h want 8000", got);
        end
    endtask

    task automatic test_random;
        logic [DW-1:0] got;
        for (int i = 0; i < 80; i++)
            send(DW'($urandom), 1'b1,
                 mk_dl($urandom_range(0, (1 << AW) - 1), $urandom_range(0, DEPTH + 20)),
                 GW'($urandom), "random", got);
    endtask

    task automatic test_wrap_clamp;
        logic [DW-1:0] got;
        // 450 clamps to DEPTH-1; streaming past DEPTH crosses the pointer wrap
        for (int i = 0; i < DEPTH + 30; i++)
            send(DW'($urandom_range(0, 16'h3FFF)), 1'b1, mk_dl(450, DEPTH - 1), mk_gn(2, 1),
                 "wrap_clamp", got);
    endtask

    task automatic test_overrun;
        int y;
        logic [DW-1:0] expv;
        logic [DW-1:0] got;
        wait_ready("overrun");
        din = 16'h1234;
        din_valid = 1'b1;
        echo_en = 1'b1;
        tap_delay = mk_dl(5, 7);
        tap_gain = mk_gn(2, 1);
        model_step(16'h1234, 1'b1, mk_dl(5, 7), mk_gn(2, 1), y);
        expv = DW'(y);
        @(negedge clk);
        din_valid = 1'b0;
        @(negedge clk);
        din = 16'h7777;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        tests++;
        if (overrun !== 1'b1 || dout_valid !== 1'b0) begin
            fails++;
            $display("FAIL overrun flag: overrun=%b valid=%b, want 1 0", overrun, dout_valid);
        end
        @(negedge clk);
        tests++;
        if (dout_valid !== 1'b1 || dout !== expv) begin
            fails++;
            $display("FAIL overrun first sample: valid=%b dout=%h, want 1 %h",
                     dout_valid, dout, expv);
        end
        for (int i = 0; i < 4; i++)
            send(DW'($urandom), 1'b1, mk_dl(1, 2), mk_gn(3, 2), "after_overrun", got);
        tests++;
        if (overrun !== 1'b1) begin
            fails++;
            $display("FAIL overrun sticky: got %b want 1", overrun);
        end
    endtask

    task automatic test_reset_mid;
        bit seen;
        logic [DW-1:0] got;
        wait_ready("reset_mid");
        din = 16'h2222;
        din_valid = 1'b1;
        echo_en = 1'b1;
        tap_delay = mk_dl(3, 4);
        tap_gain = mk_gn(1, 1);
        @(negedge clk);
        din_valid = 1'b0;
        rst = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (dout_valid === 1'b1) seen = 1'b1;
        end
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1 || overrun !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid state: in_ready=%b overrun=%b, want 1 0", in_ready, overrun);
        end
        repeat (8) begin
            @(negedge clk);
            if (dout_valid === 1'b1) seen = 1'b1;
        end
        tests++;
        if (seen) begin
            fails++;
            $display("FAIL reset_mid pulse: dout_valid seen=%b want 0", seen);
        end
        // Aborted sample never written; pointer restarts at 0 while history survives
        mdl_wp = 0;
        for (int i = 0; i < 20; i++)
            send(DW'($urandom), 1'b1,
                 mk_dl($urandom_range(0, DEPTH - 1), $urandom_range(1, DEPTH - 1)),
                 GW'($urandom), "after_reset", got);
    endtask

    initial begin
        test_reset();
        test_bypass_prefill();
        test_impulse();
        test_saturation();
        test_random();
        test_wrap_clamp();
        test_overrun();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
